// File: rtl/seq_alu.sv
// seq_alu: registered add-class unit with an iterative shift-add multiplier.
// Add-class ops finish in one cycle; MULU/MULS take WIDTH cycles.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] ra,
   input  logic [WIDTH-1:0] rb,
   output logic [WIDTH-1:0] rd,
   output logic [WIDTH-1:0] rd_hi,
   output logic [3:0]       flags,
   output logic             busy,
   output logic             done
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;
   localparam int CW = $clog2(WIDTH + 1);

   logic [0:0]         state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic               neg;
   logic               mul_s;

   logic is_inc, is_dec, is_add, is_sub;
   logic is_mulu, is_muls, is_arith;

   assign is_inc   = (op == 4'b1000);
   assign is_dec   = (op == 4'b1001);
   assign is_add   = (op == 4'b1010);
   assign is_sub   = (op == 4'b1011);
   assign is_mulu  = (op == 4'b0100);
   assign is_muls  = (op == 4'b0101);
   assign is_arith = is_inc | is_dec | is_add | is_sub;

   assign busy = (state == S_MUL);

   logic [WIDTH-1:0] add_b;
   logic             add_cin;

   always_comb begin
      add_b   = '0;
      add_cin = 1'b0;
      unique case (1'b1)
         is_inc: add_b = WIDTH'(1);
         is_dec: add_b = '1;
         is_add: add_b = rb;
         is_sub: begin
            add_b   = ~rb;
            add_cin = 1'b1;
         end
         default: ;
      endcase
   end

   logic [WIDTH:0]   add_sum;
   logic [WIDTH-1:0] add_res;
   logic             add_v;
   logic [WIDTH-1:0] arith_rd;
   logic [3:0]       arith_fl;

   assign add_sum  = {1'b0, ra} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
   assign add_res  = add_sum[WIDTH-1:0];
   assign add_v    = (ra[WIDTH-1] == add_b[WIDTH-1]) &&
                     (add_res[WIDTH-1] != ra[WIDTH-1]);
   assign arith_rd = is_arith ? add_res : '0;
   assign arith_fl = is_arith ?
                     {add_v, add_sum[WIDTH], add_res[WIDTH-1], add_res == '0} :
                     4'b0000;

   // 2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
   logic [WIDTH-1:0] ra_mag;
   logic [WIDTH-1:0] rb_mag;

   assign ra_mag = (is_muls && ra[WIDTH-1]) ? (~ra + WIDTH'(1)) : ra;
   assign rb_mag = (is_muls && rb[WIDTH-1]) ? (~rb + WIDTH'(1)) : rb;

   logic [WIDTH:0]     step_sum;
   logic [WIDTH-1:0]   step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic [2*WIDTH-1:0] prod_u;
   logic [2*WIDTH-1:0] prod;
   logic               mul_v;

   assign step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
   assign step_hi  = step_sum[WIDTH:1];
   assign step_lo  = {step_sum[0], acc_lo[WIDTH-1:1]};
   assign prod_u   = {step_hi, step_lo};
   assign prod     = neg ? (~prod_u + (2*WIDTH)'(1)) : prod_u;
   assign mul_v    = mul_s ?
                     (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}}) :
                     (prod[2*WIDTH-1:WIDTH] != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         neg    <= 1'b0;
         mul_s  <= 1'b0;
         rd     <= '0;
         rd_hi  <= '0;
         flags  <= 4'b0000;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (is_mulu || is_muls) begin
                     state  <= S_MUL;
                     cnt    <= CW'(WIDTH);
                     mcand  <= ra_mag;
                     acc_hi <= '0;
                     acc_lo <= rb_mag;
                     neg    <= is_muls & (ra[WIDTH-1] ^ rb[WIDTH-1]);
                     mul_s  <= is_muls;
                  end else begin
                     rd    <= arith_rd;
                     rd_hi <= '0;
                     flags <= arith_fl;
                     done  <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= S_IDLE;
                  rd    <= prod[WIDTH-1:0];
                  rd_hi <= prod[2*WIDTH-1:WIDTH];
                  flags <= {mul_v, mul_v, prod[2*WIDTH-1], prod == '0};
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu at WIDTH=8 and WIDTH=16.
// Vector table plus hand sequences; results checked through per-DUT queues.
module tb_seq_alu;

   localparam logic [3:0] OP_INC  = 4'b1000;
   localparam logic [3:0] OP_DEC  = 4'b1001;
   localparam logic [3:0] OP_ADD  = 4'b1010;
   localparam logic [3:0] OP_SUB  = 4'b1011;
   localparam logic [3:0] OP_MULU = 4'b0100;
   localparam logic [3:0] OP_MULS = 4'b0101;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] rd;
      logic [15:0] hi;
      logic [3:0]  fl;
      int          cyc;
      bit          w16;
   } vec_t;

   typedef struct {
      logic [15:0] rd;
      logic [15:0] hi;
      logic [3:0]  fl;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        s8, s16;
   logic [3:0]  op8, op16;
   logic [7:0]  ra8, rb8, rd8, rd_hi8;
   logic [15:0] ra16, rb16, rd16, rd_hi16;
   logic [3:0]  flags8, flags16;
   logic        busy8, busy16, done8, done16;

   int   checks = 0;
   int   errors = 0;
   exp_t q8[$];
   exp_t q16[$];
   vec_t tbl[$];
   logic [7:0] last8;

   seq_alu #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .op(op8),
      .ra(ra8), .rb(rb8), .rd(rd8), .rd_hi(rd_hi8),
      .flags(flags8), .busy(busy8), .done(done8)
   );

   seq_alu #(.WIDTH(16)) u16 (
      .clk(clk), .rst_n(rst_n), .start(s16), .op(op16),
      .ra(ra16), .rb(rb16), .rd(rd16), .rd_hi(rd_hi16),
      .flags(flags16), .busy(busy16), .done(done16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", n, act, exp);
      end
   endtask

   exp_t e8, e16;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("done_busy8", 32'(done8 & busy8), 0);
         if (done8) begin
            if (q8.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done8_spurious: got done=1, required no pending op");
            end else begin
               e8 = q8.pop_front();
               chk("rd8", 32'(rd8), 32'(e8.rd[7:0]));
               chk("rd_hi8", 32'(rd_hi8), 32'(e8.hi[7:0]));
               chk("flags8", 32'(flags8), 32'(e8.fl));
            end
         end
         chk("done_busy16", 32'(done16 & busy16), 0);
         if (done16) begin
            if (q16.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done16_spurious: got done=1, required no pending op");
            end else begin
               e16 = q16.pop_front();
               chk("rd16", 32'(rd16), 32'(e16.rd));
               chk("rd_hi16", 32'(rd_hi16), 32'(e16.hi));
               chk("flags16", 32'(flags16), 32'(e16.fl));
            end
         end
      end
   end

   task automatic scramble();
      op8  = 4'($urandom);
      ra8  = 8'($urandom);
      rb8  = 8'($urandom);
      op16 = 4'($urandom);
      ra16 = 16'($urandom);
      rb16 = 16'($urandom);
   endtask

   task automatic run(input vec_t v);
      exp_t e;
      int   nb;
      e.rd = v.rd;
      e.hi = v.hi;
      e.fl = v.fl;
      @(negedge clk);
      if (v.w16) begin
         s16 = 1'b1; op16 = v.op; ra16 = v.a; rb16 = v.b;
         q16.push_back(e);
      end else begin
         s8 = 1'b1; op8 = v.op; ra8 = v.a[7:0]; rb8 = v.b[7:0];
         q8.push_back(e);
      end
      @(posedge clk);
      #1;
      s8  = 1'b0;
      s16 = 1'b0;
      scramble();
      nb = 0;
      @(negedge clk);
      while ((v.w16 ? busy16 : busy8) && nb < 64) begin
         nb++;
         @(negedge clk);
      end
      chk("busy_cycles", nb, v.cyc);
      chk("done_pulse", 32'(v.w16 ? done16 : done8), 1);
      @(negedge clk);
      chk("done_clear", 32'(v.w16 ? done16 : done8), 0);
      chk("rd_hold", v.w16 ? 32'(rd16) : 32'(rd8),
          v.w16 ? 32'(v.rd) : 32'(v.rd[7:0]));
      if (!v.w16) last8 = v.rd[7:0];
   endtask

   initial begin
      exp_t e;
      vec_t v;
      int   nb;
      rst_n = 1'b0;
      s8 = 1'b0;
      s16 = 1'b0;
      op8 = '0; ra8 = '0; rb8 = '0;
      op16 = '0; ra16 = '0; rb16 = '0;
      last8 = '0;

      tbl.push_back('{OP_ADD,  16'h02, 16'h03, 16'h05, 16'h00, 4'b0000, 0, 1'b0});
      tbl.push_back('{OP_ADD,  16'h7F, 16'h01, 16'h80, 16'h00, 4'b1010, 0, 1'b0});
      tbl.push_back('{OP_SUB,  16'h05, 16'h05, 16'h00, 16'h00, 4'b0101, 0, 1'b0});
      tbl.push_back('{OP_SUB,  16'h03, 16'h05, 16'hFE, 16'h00, 4'b0010, 0, 1'b0});
      tbl.push_back('{OP_INC,  16'hFF, 16'h5A, 16'h00, 16'h00, 4'b0101, 0, 1'b0});
      tbl.push_back('{OP_DEC,  16'h00, 16'h5A, 16'hFF, 16'h00, 4'b0010, 0, 1'b0});
      tbl.push_back('{OP_MULU, 16'hFF, 16'hFF, 16'h01, 16'hFE, 4'b1110, 8, 1'b0});
      tbl.push_back('{OP_ADD,  16'h10, 16'h20, 16'h30, 16'h00, 4'b0000, 0, 1'b0});
      tbl.push_back('{OP_MULS, 16'hFD, 16'h04, 16'hF4, 16'hFF, 4'b0010, 8, 1'b0});
      tbl.push_back('{OP_MULS, 16'h80, 16'h80, 16'h00, 16'h40, 4'b1100, 8, 1'b0});
      tbl.push_back('{OP_MULS, 16'h00, 16'h9C, 16'h00, 16'h00, 4'b0001, 8, 1'b0});
      tbl.push_back('{OP_MULU, 16'h0D, 16'h0B, 16'h8F, 16'h00, 4'b0000, 8, 1'b0});
      tbl.push_back('{OP_MULS, 16'h7F, 16'h81, 16'hFF, 16'hC0, 4'b1110, 8, 1'b0});
      tbl.push_back('{4'b0000, 16'h55, 16'hAA, 16'h00, 16'h00, 4'b0000, 0, 1'b0});
      tbl.push_back('{OP_ADD,  16'hFF, 16'h01, 16'h00, 16'h00, 4'b0101, 0, 1'b0});
      tbl.push_back('{4'b1111, 16'hFF, 16'hFF, 16'h00, 16'h00, 4'b0000, 0, 1'b0});
      tbl.push_back('{OP_MULU, 16'hFFFF, 16'h0002, 16'hFFFE, 16'h0001, 4'b1100, 16, 1'b1});
      tbl.push_back('{OP_MULS, 16'hFFFD, 16'h0004, 16'hFFF4, 16'hFFFF, 4'b0010, 16, 1'b1});
      tbl.push_back('{OP_MULS, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 4'b1100, 16, 1'b1});
      tbl.push_back('{OP_MULS, 16'h0000, 16'hFF9C, 16'h0000, 16'h0000, 4'b0001, 16, 1'b1});
      tbl.push_back('{OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b1010, 0, 1'b1});
      tbl.push_back('{OP_MULU, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 4'b1100, 16, 1'b1});

      repeat (3) @(negedge clk);
      chk("rst_rd8", 32'(rd8), 0);
      chk("rst_hi8", 32'(rd_hi8), 0);
      chk("rst_fl8", 32'(flags8), 0);
      chk("rst_busy8", 32'(busy8), 0);
      chk("rst_done8", 32'(done8), 0);
      chk("rst_busy16", 32'(busy16), 0);
      rst_n = 1'b1;

      foreach (tbl[i]) run(tbl[i]);

      // start during a multiply must be dropped
      @(negedge clk);
      s8 = 1'b1; op8 = OP_MULU; ra8 = 8'hFF; rb8 = 8'hFF;
      e.rd = 16'h01; e.hi = 16'hFE; e.fl = 4'b1110;
      q8.push_back(e);
      @(posedge clk);
      #1;
      s8 = 1'b0;
      nb = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!busy8) break;
         nb++;
         s8 = (nb == 3);
         if (nb == 3) begin
            op8 = OP_ADD; ra8 = 8'h01; rb8 = 8'h01;
         end
         if (nb == 4) chk("rd_held_busy", 32'(rd8), 32'(last8));
      end
      s8 = 1'b0;
      chk("ignore_busy_cycles", nb, 8);
      chk("ignore_done", 32'(done8), 1);
      @(negedge clk);

      // reset in the third busy cycle aborts the multiply
      s8 = 1'b1; op8 = OP_MULU; ra8 = 8'hFF; rb8 = 8'hFF;
      @(posedge clk);
      #1;
      s8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", 32'(busy8), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_rd", 32'(rd8), 0);
      chk("abort_hi", 32'(rd_hi8), 0);
      chk("abort_fl", 32'(flags8), 0);
      chk("abort_busy", 32'(busy8), 0);
      chk("abort_done", 32'(done8), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort_no_done", 32'(done8), 0);
      v = '{OP_ADD, 16'h02, 16'h03, 16'h05, 16'h00, 4'b0000, 0, 1'b0};
      run(v);

      // ADDs issued from the MULU done cycle onward
      @(negedge clk);
      s8 = 1'b1; op8 = OP_MULU; ra8 = 8'h0D; rb8 = 8'h0B;
      e.rd = 16'h8F; e.hi = 16'h00; e.fl = 4'b0000;
      q8.push_back(e);
      @(posedge clk);
      #1;
      s8 = 1'b0;
      nb = 0;
      @(negedge clk);
      while (busy8 && nb < 64) begin
         nb++;
         @(negedge clk);
      end
      chk("b2b_busy_cycles", nb, 8);
      chk("b2b_done0", 32'(done8), 1);
      s8 = 1'b1; op8 = OP_ADD; ra8 = 8'h01; rb8 = 8'h02;
      e.rd = 16'h03; e.hi = 16'h00; e.fl = 4'b0000;
      q8.push_back(e);
      @(posedge clk);
      #1;
      ra8 = 8'h80; rb8 = 8'h80;
      e.rd = 16'h00; e.hi = 16'h00; e.fl = 4'b1101;
      q8.push_back(e);
      @(negedge clk);
      chk("b2b_done1", 32'(done8), 1);
      @(posedge clk);
      #1;
      s8 = 1'b0;
      @(negedge clk);
      chk("b2b_done2", 32'(done8), 1);
      @(negedge clk);
      chk("b2b_done3", 32'(done8), 0);

      repeat (2) @(negedge clk);
      chk("q8_drained", q8.size(), 0);
      chk("q16_drained", q16.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
